// File: rtl/pattern_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pattern_gen_pkg                                        |
// | Description : Shared widths, pattern selectors and FSM state type    |
// |               for the synthetic event-window pattern source.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package pattern_gen_pkg;

  // Tracker-wide datapath widths
  localparam int PG_DIGI_BITS       = 32;  // data word width
  localparam int PG_EVENT_SIZE_BITS = 10;  // window size in 64-bit beats
  localparam int PG_SPILL_TAG_BITS  = 20;  // event-window tag width

  // Largest window actually written; bigger requests are truncated
  localparam int PATTERN_MAX_BEATS  = 1000;

  // Data pattern selectors
  localparam logic [1:0] PATTERN_TYPE_CNT  = 2'd0;  // running seed counter
  localparam logic [1:0] PATTERN_TYPE_WALK = 2'd1;  // walking one
  localparam logic [1:0] PATTERN_TYPE_ALT  = 2'd2;  // A5/5A alternation
  localparam logic [1:0] PATTERN_TYPE_TAG  = 2'd3;  // {tag, word index}

  // Alternating pattern bytes
  localparam logic [7:0] ALT_EVEN_BYTE = 8'hA5;
  localparam logic [7:0] ALT_ODD_BYTE  = 8'h5A;

  // Window sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } pg_state_t;

endpackage : pattern_gen_pkg
`default_nettype wire

// File: rtl/pattern_word_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pattern_word_gen                                       |
// | Description : Combinational data-word generator. Maps pattern type,  |
// |               word index, window tag and running seed to one word.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pattern_word_gen
  import pattern_gen_pkg::*;
#(
  parameter int DIGI_BITS = PG_DIGI_BITS,
  parameter int IDX_BITS  = PG_EVENT_SIZE_BITS + 1
) (
  input  logic [1:0]           pattern_type,
  input  logic [IDX_BITS-1:0]  w,
  input  logic [15:0]          tag16,
  input  logic [DIGI_BITS-1:0] seed,
  output logic [DIGI_BITS-1:0] word
);

  // Select the word for index w; walking one wraps every 32 words
  always_comb begin
    word = '0;
    case (pattern_type)
      PATTERN_TYPE_CNT:  word = seed;
      PATTERN_TYPE_WALK: word = DIGI_BITS'(1) << w[4:0];
      PATTERN_TYPE_ALT:  word = w[0] ? {(DIGI_BITS/8){ALT_ODD_BYTE}}
                                     : {(DIGI_BITS/8){ALT_EVEN_BYTE}};
      default:           word = DIGI_BITS'({tag16, 16'(w)});
    endcase
  end

endmodule : pattern_word_gen
`default_nettype wire

// File: rtl/pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pattern_gen                                            |
// | Description : Synthetic event-window source. Each start writes one   |
// |               window of deterministic words (two per beat) and ends  |
// |               with a one-cycle done strobe carrying size/tag/ovfl.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int DIGI_BITS       = PG_DIGI_BITS,
  parameter int EVENT_SIZE_BITS = PG_EVENT_SIZE_BITS,
  parameter int SPILL_TAG_BITS  = PG_SPILL_TAG_BITS,
  parameter int MAX_BEATS       = PATTERN_MAX_BEATS
) (
  input  logic                       serdesclk,
  input  logic                       serdes_reset,
  input  logic                       start,
  input  logic                       pattern_init,
  input  logic [1:0]                 pattern_type,
  input  logic [EVENT_SIZE_BITS-1:0] pattern_nbeats,
  input  logic                       ewfifo_full,
  output logic                       curr_ewfifo_wr,
  output logic                       ew_done,
  output logic                       ew_ovfl,
  output logic                       ew_fifo_we,
  output logic [DIGI_BITS-1:0]       ew_fifo_data,
  output logic [EVENT_SIZE_BITS-1:0] ew_size,
  output logic [SPILL_TAG_BITS-1:0]  ew_tag,
  output logic                       start_missed
);

  // Word index spans 2*beats, so it needs one extra bit
  localparam int IDX_BITS = EVENT_SIZE_BITS + 1;
  localparam logic [EVENT_SIZE_BITS-1:0] MAX_NB = EVENT_SIZE_BITS'(MAX_BEATS);

  pg_state_t                  state;
  logic [1:0]                 type_r;
  logic [EVENT_SIZE_BITS-1:0] nb_r;
  logic                       ovfl_r;
  logic [SPILL_TAG_BITS-1:0]  tag_r;
  logic [SPILL_TAG_BITS-1:0]  tag_cnt;
  logic [IDX_BITS-1:0]        idx_r;
  logic [DIGI_BITS-1:0]       seed_r;

  logic                       req_ovfl;
  logic [EVENT_SIZE_BITS-1:0] nb_clamped;
  logic [IDX_BITS-1:0]        last_idx;
  logic                       write_now;
  logic [DIGI_BITS-1:0]       next_word;

  assign req_ovfl   = (pattern_nbeats > MAX_NB);
  assign nb_clamped = req_ovfl ? MAX_NB : pattern_nbeats;
  // Index of the final word of the window (2*nb - 1); only used when nb > 0
  assign last_idx   = {nb_r, 1'b0} - IDX_BITS'(1);
  assign write_now  = (state == ST_GEN) && !ewfifo_full;

  pattern_word_gen #(
    .DIGI_BITS (DIGI_BITS),
    .IDX_BITS  (IDX_BITS)
  ) u_word_gen (
    .pattern_type (type_r),
    .w            (idx_r),
    .tag16        (tag_r[15:0]),
    .seed         (seed_r),
    .word         (next_word)
  );

  // Window sequencer: latch request, stream words under backpressure, report
  always_ff @(posedge serdesclk or posedge serdes_reset) begin
    if (serdes_reset) begin
      state          <= ST_IDLE;
      type_r         <= '0;
      nb_r           <= '0;
      ovfl_r         <= 1'b0;
      tag_r          <= '0;
      idx_r          <= '0;
      ew_fifo_we     <= 1'b0;
      ew_fifo_data   <= '0;
      ew_done        <= 1'b0;
      ew_size        <= '0;
      ew_tag         <= '0;
      ew_ovfl        <= 1'b0;
      curr_ewfifo_wr <= 1'b0;
    end else begin
      ew_fifo_we <= 1'b0;
      ew_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            type_r <= pattern_type;
            nb_r   <= nb_clamped;
            ovfl_r <= req_ovfl;
            tag_r  <= tag_cnt;
            idx_r  <= '0;
            state  <= (nb_clamped == '0) ? ST_DONE : ST_GEN;
          end
        end
        ST_GEN: begin
          if (!ewfifo_full) begin
            ew_fifo_we   <= 1'b1;
            ew_fifo_data <= next_word;
            idx_r        <= idx_r + IDX_BITS'(1);
            if (idx_r == last_idx) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          ew_done        <= 1'b1;
          ew_size        <= nb_r;
          ew_tag         <= tag_r;
          ew_ovfl        <= ovfl_r;
          curr_ewfifo_wr <= ~curr_ewfifo_wr;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Tag counter, running seed and missed-start flag; pattern_init overrides updates
  always_ff @(posedge serdesclk or posedge serdes_reset) begin
    if (serdes_reset) begin
      tag_cnt      <= '0;
      seed_r       <= '0;
      start_missed <= 1'b0;
    end else if (pattern_init) begin
      tag_cnt      <= '0;
      seed_r       <= '0;
      start_missed <= 1'b0;
    end else begin
      if (state == ST_DONE) begin
        tag_cnt <= tag_cnt + SPILL_TAG_BITS'(1);
      end
      if (write_now && (type_r == PATTERN_TYPE_CNT)) begin
        seed_r <= seed_r + DIGI_BITS'(1);
      end
      if (start && (state != ST_IDLE)) begin
        start_missed <= 1'b1;
      end
    end
  end

endmodule : pattern_gen
`default_nettype wire

// File: tb/tb_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_pattern_gen                                         |
// | Description : Self-checking bench for pattern_gen: a table of        |
// |               windows plus directed backpressure, missed-start,      |
// |               init and mid-window reset sequences.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_pattern_gen;

  logic        serdesclk      = 1'b0;
  logic        serdes_reset   = 1'b1;
  logic        start          = 1'b0;
  logic        pattern_init   = 1'b0;
  logic [1:0]  pattern_type   = 2'd0;
  logic [9:0]  pattern_nbeats = 10'd0;
  logic        ewfifo_full    = 1'b0;
  logic        curr_ewfifo_wr;
  logic        ew_done;
  logic        ew_ovfl;
  logic        ew_fifo_we;
  logic [31:0] ew_fifo_data;
  logic [9:0]  ew_size;
  logic [19:0] ew_tag;
  logic        start_missed;

  always #5 serdesclk = ~serdesclk;

  pattern_gen dut (
    .serdesclk      (serdesclk),
    .serdes_reset   (serdes_reset),
    .start          (start),
    .pattern_init   (pattern_init),
    .pattern_type   (pattern_type),
    .pattern_nbeats (pattern_nbeats),
    .ewfifo_full    (ewfifo_full),
    .curr_ewfifo_wr (curr_ewfifo_wr),
    .ew_done        (ew_done),
    .ew_ovfl        (ew_ovfl),
    .ew_fifo_we     (ew_fifo_we),
    .ew_fifo_data   (ew_fifo_data),
    .ew_size        (ew_size),
    .ew_tag         (ew_tag),
    .start_missed   (start_missed)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Collected writes and the report captured at each done strobe
  logic [31:0] wq[$];
  int          done_cnt = 0;
  logic [9:0]  d_size;
  logic [19:0] d_tag;
  logic        d_ovfl;
  logic        d_curr;

  // Reference model state
  logic        exp_curr = 1'b0;
  logic [31:0] mseed    = 32'd0;

  // Sample outputs mid-cycle, away from the active edge
  always @(negedge serdesclk) begin
    if (ew_fifo_we) wq.push_back(ew_fifo_data);
    if (ew_done) begin
      done_cnt++;
      d_size = ew_size;
      d_tag  = ew_tag;
      d_ovfl = ew_ovfl;
      d_curr = curr_ewfifo_wr;
    end
  end

  typedef struct {
    logic [1:0]  t;
    logic [9:0]  nb;
    int          n_we;
    logic [9:0]  size;
    logic        ovfl;
    logic [19:0] tag;
    logic [31:0] first;
    logic [31:0] last;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge serdesclk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input logic [1:0] t, input int w,
                                           input logic [19:0] tag, input logic [31:0] seed);
    logic [31:0] wv;
    wv = 32'(w);
    case (t)
      2'd0:    return seed + wv;
      2'd1:    return 32'h1 << (w % 32);
      2'd2:    return wv[0] ? 32'h5A5A5A5A : 32'hA5A5A5A5;
      default: return {tag[15:0], wv[15:0]};
    endcase
  endfunction

  task automatic wait_done(input int d0, input int budget, output bit got);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) break;
      tick();
    end
    got = (done_cnt != d0);
  endtask

  // After a done is seen: strobe must be one cycle wide; model toggles the FIFO select
  task automatic after_done(input bit got);
    chk("done_seen", longint'(got), 1);
    @(negedge serdesclk);
    chk("done_pulse", longint'(ew_done), 0);
    tick();
    exp_curr = ~exp_curr;
    chk("curr_ewfifo_wr", longint'(d_curr), longint'(exp_curr));
  endtask

  task automatic run_check(input logic [1:0] t, input logic [9:0] nb, input int exp_we,
                           input logic [9:0] exp_size, input logic exp_ovfl,
                           input logic [19:0] exp_tag);
    int d0;
    int bad;
    bit got;
    d0  = done_cnt;
    bad = 0;
    wq.delete();
    pattern_type   = t;
    pattern_nbeats = nb;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0, 2500, got);
    after_done(got);
    chk("we_count", longint'(wq.size()), longint'(exp_we));
    chk("ew_size",  longint'(d_size),    longint'(exp_size));
    chk("ew_tag",   longint'(d_tag),     longint'(exp_tag));
    chk("ew_ovfl",  longint'(d_ovfl),    longint'(exp_ovfl));
    for (int w = 0; w < wq.size(); w++)
      if (wq[w] !== exp_word(t, w, exp_tag, mseed)) bad++;
    chk("data_words_bad", longint'(bad), 0);
    if (t == 2'd0) mseed = mseed + 32'(exp_we);
  endtask

  initial begin
    int  d0;
    bit  got;
    logic [31:0] exp_bp[4];

    //       type  nbeats n_we  size   ovfl  tag    first          last
    vt[0] = '{2'd2, 10'd3,    6,    10'd3,    1'b0, 20'd0, 32'hA5A5A5A5, 32'h5A5A5A5A};
    vt[1] = '{2'd0, 10'd2,    4,    10'd2,    1'b0, 20'd1, 32'd0,        32'd3};
    vt[2] = '{2'd0, 10'd2,    4,    10'd2,    1'b0, 20'd2, 32'd4,        32'd7};
    vt[3] = '{2'd0, 10'd2,    4,    10'd2,    1'b0, 20'd3, 32'd8,        32'd11};
    vt[4] = '{2'd1, 10'd20,   40,   10'd20,   1'b0, 20'd4, 32'h1,        32'h80};
    vt[5] = '{2'd3, 10'd2,    4,    10'd2,    1'b0, 20'd5, 32'h00050000, 32'h00050003};
    vt[6] = '{2'd1, 10'd1023, 2000, 10'd1000, 1'b1, 20'd6, 32'h1,        32'h00008000};
    vt[7] = '{2'd0, 10'd0,    0,    10'd0,    1'b0, 20'd7, 32'd0,        32'd0};
    vt[8] = '{2'd3, 10'd1000, 2000, 10'd1000, 1'b0, 20'd8, 32'h00080000, 32'h000807CF};

    // Reset state
    tick(); tick();
    chk("reset_ctl_data", longint'({curr_ewfifo_wr, ew_done, ew_ovfl, ew_fifo_we, ew_fifo_data}), 0);
    chk("reset_size_tag", longint'({ew_size, ew_tag, start_missed}), 0);
    serdes_reset = 1'b0;
    tick();

    // Table of windows with no backpressure
    for (int i = 0; i < 9; i++) begin
      run_check(vt[i].t, vt[i].nb, vt[i].n_we, vt[i].size, vt[i].ovfl, vt[i].tag);
      if (vt[i].n_we > 0) begin
        chk("first_word", longint'(wq[0]), longint'(vt[i].first));
        chk("last_word",  longint'(wq[wq.size()-1]), longint'(vt[i].last));
      end
    end
    chk("no_missed_in_table", longint'(start_missed), 0);

    // Backpressure: clear tag counter, burn tags 0..6, then type 3 window with tag 7
    pattern_init = 1'b1; tick(); pattern_init = 1'b0;
    mseed = 32'd0;
    for (int k = 0; k < 7; k++) run_check(2'd0, 10'd0, 0, 10'd0, 1'b0, 20'(k));
    wq.delete();
    d0 = done_cnt;
    pattern_type = 2'd3; pattern_nbeats = 10'd2;
    start = 1'b1; tick(); start = 1'b0;
    @(negedge serdesclk);
    chk("no_we_on_start_cycle", longint'(ew_fifo_we), 0);
    tick();
    ewfifo_full = 1'b1;
    @(negedge serdesclk);
    chk("first_we_cycle", longint'({ew_fifo_we, ew_fifo_data}), longint'({1'b1, 32'h00070000}));
    for (int k = 0; k < 5; k++) tick();
    ewfifo_full = 1'b0;
    chk("hold_while_full", longint'(wq.size()), 1);
    wait_done(d0, 50, got);
    after_done(got);
    exp_bp = '{32'h00070000, 32'h00070001, 32'h00070002, 32'h00070003};
    chk("bp_we_count", longint'(wq.size()), 4);
    for (int k = 0; k < 4; k++)
      if (k < wq.size()) chk("bp_word", longint'(wq[k]), longint'(exp_bp[k]));
    chk("bp_tag", longint'(d_tag), 7);

    // Start during GEN is dropped and flagged; window still ends once
    wq.delete();
    d0 = done_cnt;
    pattern_type = 2'd0; pattern_nbeats = 10'd4;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(d0, 50, got);
    after_done(got);
    chk("missed_tag", longint'(d_tag), 8);
    chk("missed_we_count", longint'(wq.size()), 8);
    tick(); tick(); tick();
    chk("start_missed_set", longint'(start_missed), 1);
    chk("no_queued_window", longint'(done_cnt - d0), 1);
    pattern_init = 1'b1; tick(); pattern_init = 1'b0;
    mseed = 32'd0;
    chk("start_missed_cleared", longint'(start_missed), 0);
    run_check(2'd0, 10'd0, 0, 10'd0, 1'b0, 20'd0);

    // Start together with init in IDLE latches the pre-clear tag (1)
    d0 = done_cnt;
    pattern_type = 2'd0; pattern_nbeats = 10'd0;
    start = 1'b1; pattern_init = 1'b1; tick(); start = 1'b0; pattern_init = 1'b0;
    wait_done(d0, 20, got);
    after_done(got);
    chk("start_init_tag", longint'(d_tag), 1);

    // Init on the DONE edge wins over the tag increment
    d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    pattern_init = 1'b1; tick(); pattern_init = 1'b0;
    wait_done(d0, 20, got);
    after_done(got);
    chk("init_at_done_window_tag", longint'(d_tag), 1);
    run_check(2'd2, 10'd1, 2, 10'd1, 1'b0, 20'd0);

    // Asynchronous reset in the middle of a 4-beat window
    wq.delete();
    d0 = done_cnt;
    pattern_type = 2'd0; pattern_nbeats = 10'd4;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 20 && wq.size() < 3; k++) tick();
    chk("reached_word3", longint'(wq.size() >= 3), 1);
    serdes_reset = 1'b1;
    #1;
    chk("rst_ctl_data", longint'({curr_ewfifo_wr, ew_done, ew_ovfl, ew_fifo_we, ew_fifo_data}), 0);
    chk("rst_size_tag", longint'({ew_size, ew_tag, start_missed}), 0);
    tick(); tick();
    serdes_reset = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("no_done_after_reset", longint'(done_cnt - d0), 0);
    exp_curr = 1'b0;
    mseed    = 32'd0;
    run_check(2'd0, 10'd1, 2, 10'd1, 1'b0, 20'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pattern_gen
`default_nettype wire

// File: doc/pattern_gen.md
Name: pattern_gen

Overview:
- Synthetic event-window source for the DAQ path. It sits directly upstream of the DIGI/PATTERN select stage and drives its PATTRN_* inputs.
- On each start pulse it writes one event window of deterministic 32-bit words into the event-window FIFO path.
- At the end of the window it reports size, tag and overflow with a one-cycle done strobe, exactly as the DIGI path does. Used for link/DMA bring-up without front-end hits.

Parameters:
- DIGI_BITS, `DIGI_BITS (32), data word width.
- EVENT_SIZE_BITS, `EVENT_SIZE_BITS (10), width of window size in 64-bit beats.
- SPILL_TAG_BITS, `SPILL_TAG_BITS (20), width of event-window tag.
- MAX_BEATS, 1000, largest window written; larger requests are truncated and flagged.

Ports:
- serdesclk  in  1  sole clock.
- serdes_reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle window start (driven by PATTRN_axi_start_on_serdesclk).
- pattern_init  in  1  synchronous clear of tag counter and running data seed.
- pattern_type  in  2  data pattern select, latched at window start.
- pattern_nbeats  in  EVENT_SIZE_BITS  requested beats per window, latched at window start.
- ewfifo_full  in  1  backpressure; no write is issued while high.
- curr_ewfifo_wr  out  1  ping-pong FIFO select; toggles after each window.
- ew_done  out  1  one-cycle end-of-window strobe.
- ew_ovfl  out  1  request exceeded MAX_BEATS; valid with ew_done and held until the next window.
- ew_fifo_we  out  1  data write enable.
- ew_fifo_data  out  DIGI_BITS  data word.
- ew_size  out  EVENT_SIZE_BITS  beats actually written; valid with ew_done and held.
- ew_tag  out  SPILL_TAG_BITS  window tag; valid with ew_done and held.
- start_missed  out  1  sticky; start seen while busy. Cleared by pattern_init.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; tag counter 0; data seed 0.
- FSM states: IDLE, GEN, DONE.
- IDLE, on start:
  - Latch type.
  - Latch nb = min(pattern_nbeats, MAX_BEATS).
  - Set ovfl_r = (pattern_nbeats > MAX_BEATS).
  - Latch tag_r = tag counter.
  - Clear word index.
  - Go to GEN, or to DONE if nb == 0.
- GEN:
  - Each cycle with ewfifo_full == 0, assert ew_fifo_we with the next word and increment the word index.
  - With ewfifo_full == 1, hold: no we, index frozen.
  - A beat is two words. After word 2*nb-1 is written, go to DONE.
  - First we occurs one cycle after start at the earliest.
- DONE (one cycle):
  - ew_done = 1; ew_size = nb; ew_tag = tag_r; ew_ovfl = ovfl_r.
  - curr_ewfifo_wr toggles on the same edge that ew_done is registered.
  - Tag counter increments, wrapping modulo 2^SPILL_TAG_BITS.
  - Return to IDLE. A start is accepted again the cycle after DONE.
- Start in GEN or DONE: ignored, sets start_missed. No queuing.
- Data patterns (w = word index within window):
  - type 0: running counter seed; seed increments per word written and persists across windows.
  - type 1: walking one, 1 << (w mod 32).
  - type 2: 0xA5A5A5A5 on even w, 0x5A5A5A5A on odd w.
  - type 3: {tag_r[15:0], w[15:0]}.
- pattern_init:
  - Clears tag counter, seed and start_missed on the next edge.
  - A window in progress keeps its latched tag_r.
  - If pattern_init coincides with DONE, the counter ends at 0; init wins over the increment.
- Simultaneous start and pattern_init in IDLE: window latches the pre-clear tag counter value.
- Async reset mid-window: immediate return to reset state; no ew_done; partial data is not flagged (the FIFO controller flushes on reset).
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared header tracker_params.vh holds DIGI_BITS, EVENT_SIZE_BITS, SPILL_TAG_BITS, plus new defines PATTERN_TYPE_CNT/WALK/ALT/TAG (0..3) and PATTERN_MAX_BEATS.
- One sub-module, pattern_word_gen: combinational, type + w + tag_r + seed in, word out. Instantiated once in pattern_gen.

Test Plan:
- Reset, start with type 2, nbeats 3, no backpressure -> 6 we cycles with data A5A5A5A5/5A5A5A5A alternating; ew_done 1 cycle later; ew_size 3, ew_tag 0, ew_ovfl 0; curr_ewfifo_wr 0->1.
- Three back-to-back windows, type 0, nbeats 2 -> data 0..11 contiguous across windows; tags 0,1,2; curr_ewfifo_wr toggles each done.
- nbeats 1023 with MAX_BEATS 1000 -> exactly 2000 we; ew_size 1000; ew_ovfl 1.
- ewfifo_full high for 5 cycles mid-window, type 3, tag 7 -> no we while full; words 0x00070000..0x00070003 in order with no gaps or duplicates.
- Start during GEN -> ignored, start_missed 1. Then pattern_init -> start_missed 0, next ew_tag 0. nbeats 0 -> ew_done with ew_size 0 and no we.
- serdes_reset asserted at word 3 of a 4-beat window -> all outputs 0 next sample; no ew_done. After release, start -> tag 0, curr_ewfifo_wr toggles from 0.
